// File: rtl/pfb_udiv_pkg.sv
// Shared definitions for the iterative unsigned divider.
// Optional build macro used by the top: PFB_UDIV_SKID_EN.
package pfb_udiv_pkg;

    localparam int DIVIDEND_WIDTH = 23;
    localparam int DIVISOR_WIDTH  = 13;
    localparam int CNT_WIDTH      = 5;

    // Quotient reported for a zero divisor (saturated to all ones).
    localparam logic [DIVIDEND_WIDTH-1:0] QUOT_SAT = '1;

    // One iteration per dividend bit.
    localparam logic [CNT_WIDTH-1:0] CNT_START = CNT_WIDTH'(DIVIDEND_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } udiv_state_t;

endpackage

// File: rtl/pfb_udiv_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, then subtract the divisor if it fits.
// The stored partial remainder is always below the divisor, so only its low
// DIVISOR_WIDTH bits carry information; the shifted value needs one extra bit.
module pfb_udiv_step
    import pfb_udiv_pkg::*;
(
    input  logic [DIVISOR_WIDTH-1:0] i_pr,
    input  logic                     i_bit,
    input  logic [DIVISOR_WIDTH-1:0] i_divisor,
    output logic [DIVISOR_WIDTH-1:0] o_pr,
    output logic                     o_qBit
);

    logic [DIVISOR_WIDTH:0] w_shifted;

    // Compare/subtract; the difference is below the divisor so it fits the narrow width.
    always_comb begin
        w_shifted = {i_pr, i_bit};
        o_qBit    = (w_shifted >= {1'b0, i_divisor});
        o_pr      = o_qBit ? DIVISOR_WIDTH'(w_shifted - {1'b0, i_divisor})
                           : w_shifted[DIVISOR_WIDTH-1:0];
    end

endmodule

// File: rtl/pfb_multichannel_decimator_udiv_23ns_13ns_seq.sv
// Iterative unsigned restoring divider, one quotient bit per clock, with
// valid/ready handshakes on both sides.
// Optional macro PFB_UDIV_SKID_EN adds a one-entry result register so the
// core can start the next division while a result waits for out_ready.
module pfb_multichannel_decimator_udiv_23ns_13ns_seq
    import pfb_udiv_pkg::*;
(
    input  logic                      ap_clk,
    input  logic                      ap_rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DIVIDEND_WIDTH-1:0] dividend,
    input  logic [DIVISOR_WIDTH-1:0]  divisor,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DIVIDEND_WIDTH-1:0] quotient,
    output logic [DIVISOR_WIDTH-1:0]  remainder,
    output logic                      div_by_zero
);

    udiv_state_t                r_state;
    udiv_state_t                w_nextState;
    logic [CNT_WIDTH-1:0]       r_cnt;
    logic [DIVIDEND_WIDTH-1:0]  r_dividend;
    logic [DIVISOR_WIDTH-1:0]   r_divisor;
    logic [DIVISOR_WIDTH-1:0]   r_pr;
    logic [DIVIDEND_WIDTH-1:0]  r_quot;
    logic                       r_dbz;

    logic                       w_finish;
    logic                       w_sinkFree;
    logic [DIVIDEND_WIDTH-1:0]  w_resQuot;
    logic [DIVISOR_WIDTH-1:0]   w_resRem;
    logic                       w_resDbz;
    logic [DIVISOR_WIDTH-1:0]   w_stepPr;
    logic                       w_qBit;

    pfb_udiv_step u_step (
        .i_pr      (r_pr),
        .i_bit     (r_dividend[DIVIDEND_WIDTH-1]),
        .i_divisor (r_divisor),
        .o_pr      (w_stepPr),
        .o_qBit    (w_qBit)
    );

`ifdef PFB_UDIV_SKID_EN
    logic                       r_skidValid;
    logic [DIVIDEND_WIDTH-1:0]  r_skidQuot;
    logic [DIVISOR_WIDTH-1:0]   r_skidRem;
    logic                       r_skidDbz;

    assign w_sinkFree = !r_skidValid || out_ready;
`else
    assign w_sinkFree = out_ready;
`endif

    // Next state plus the finished result, valid whenever w_finish is high.
    always_comb begin
        w_nextState = r_state;
        w_finish    = 1'b0;
        w_resQuot   = {r_quot[DIVIDEND_WIDTH-2:0], w_qBit};
        w_resRem    = w_stepPr;
        w_resDbz    = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    if (divisor == '0) begin
                        w_finish  = 1'b1;
                        w_resQuot = QUOT_SAT;
                        w_resRem  = dividend[DIVISOR_WIDTH-1:0];
                        w_resDbz  = 1'b1;
                    end else begin
                        w_nextState = BUSY;
                    end
                end
            end
            BUSY: begin
                if (r_cnt == CNT_WIDTH'(1)) begin
                    w_finish = 1'b1;
                end
            end
            DONE: begin
                if (w_sinkFree) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
`ifdef PFB_UDIV_SKID_EN
        if (w_finish) begin
            w_nextState = w_sinkFree ? IDLE : DONE;
        end
`else
        if (w_finish) begin
            w_nextState = DONE;
        end
`endif
    end

    // State register.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Operand latch, shift/subtract iterations and result capture.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            r_dividend <= '0;
            r_divisor  <= '0;
            r_pr       <= '0;
            r_quot     <= '0;
            r_dbz      <= 1'b0;
            r_cnt      <= '0;
        end else if (w_finish) begin
            r_quot <= w_resQuot;
            r_pr   <= w_resRem;
            r_dbz  <= w_resDbz;
            r_cnt  <= '0;
        end else if (r_state == IDLE && in_valid) begin
            r_dividend <= dividend;
            r_divisor  <= divisor;
            r_pr       <= '0;
            r_quot     <= '0;
            r_dbz      <= 1'b0;
            r_cnt      <= CNT_START;
        end else if (r_state == BUSY) begin
            r_dividend <= {r_dividend[DIVIDEND_WIDTH-2:0], 1'b0};
            r_pr       <= w_stepPr;
            r_quot     <= {r_quot[DIVIDEND_WIDTH-2:0], w_qBit};
            r_cnt      <= r_cnt - CNT_WIDTH'(1);
        end
    end

    assign in_ready = (r_state == IDLE);

`ifdef PFB_UDIV_SKID_EN
    // Result register: filled straight from a finishing division, or from a
    // core stalled in DONE once the previous result has drained.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            r_skidValid <= 1'b0;
            r_skidQuot  <= '0;
            r_skidRem   <= '0;
            r_skidDbz   <= 1'b0;
        end else if (w_finish && w_sinkFree) begin
            r_skidValid <= 1'b1;
            r_skidQuot  <= w_resQuot;
            r_skidRem   <= w_resRem;
            r_skidDbz   <= w_resDbz;
        end else if (r_state == DONE && w_sinkFree) begin
            r_skidValid <= 1'b1;
            r_skidQuot  <= r_quot;
            r_skidRem   <= r_pr;
            r_skidDbz   <= r_dbz;
        end else if (out_ready) begin
            r_skidValid <= 1'b0;
        end
    end

    assign out_valid   = r_skidValid;
    assign quotient    = r_skidQuot;
    assign remainder   = r_skidRem;
    assign div_by_zero = r_skidDbz;
`else
    assign out_valid   = (r_state == DONE);
    assign quotient    = r_quot;
    assign remainder   = r_pr;
    assign div_by_zero = r_dbz;
`endif

endmodule

// File: tb/tb_pfb_multichannel_decimator_udiv_23ns_13ns_seq.sv
// Self-checking bench for the iterative unsigned divider (also built with PFB_UDIV_SKID_EN).
`timescale 1ns/1ps
module tb_pfb_multichannel_decimator_udiv_23ns_13ns_seq;

    localparam int DW = 23;
    localparam int SW = 13;

    logic          ap_clk;
    logic          ap_rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] dividend;
    logic [SW-1:0] divisor;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] quotient;
    logic [SW-1:0] remainder;
    logic          div_by_zero;

    pfb_multichannel_decimator_udiv_23ns_13ns_seq dut (
        .ap_clk      (ap_clk),
        .ap_rst_n    (ap_rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    typedef struct {
        logic [DW-1:0] q;
        logic [SW-1:0] r;
        logic          dbz;
        int            acc;
    } exp_t;

    exp_t expQ[$];
    int   nChecks = 0;
    int   nErrors = 0;
    int   cycle = 0;
    int   nAccepted = 0;
    int   lastAcceptCycle = 0;
    bit   prevStall = 0;
    bit   frontSeen = 0;

    // Free-running clock and cycle counter.
    initial begin
        ap_clk = 1'b0;
        forever #5 ap_clk = ~ap_clk;
    end

    always @(posedge ap_clk) cycle++;

    // Hard stop in case something hangs.
    initial begin
        #900000;
        $display("[TB] FAIL watchdog: run still active at cycle %0d (required: finished)", cycle);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tally(input string name, input bit ok, input string detail);
        nChecks++;
        if (!ok) begin
            nErrors++;
            $display("[TB] FAIL %s: %s", name, detail);
        end
    endtask

    // Reference model and compare process: every accepted operation becomes an
    // expected result computed with plain division; every cycle the output is
    // valid it must match the oldest outstanding expectation.
    always @(negedge ap_clk) begin
        exp_t   e;
        int     lat;
        int     nomLat;
        longint a;
        longint b;
        if (!ap_rst_n) begin
            expQ.delete();
            prevStall = 0;
            frontSeen = 0;
        end else begin
            if (prevStall) begin
                tally("validHeld", out_valid === 1'b1,
                      $sformatf("out_valid=%b while stalled, required 1", out_valid));
            end
            if (out_valid) begin
                if (expQ.size() == 0) begin
                    tally("unexpectedResult", 1'b0,
                          $sformatf("out_valid=1 q=%0d r=%0d with no outstanding operation", quotient, remainder));
                end else begin
                    e = expQ[0];
                    if (!frontSeen) begin
                        frontSeen = 1;
                        lat = cycle - e.acc;
                        nomLat = e.dbz ? 1 : DW + 1;
`ifdef PFB_UDIV_SKID_EN
                        tally("latency", lat >= nomLat,
                              $sformatf("latency %0d, required at least %0d", lat, nomLat));
`else
                        tally("latency", lat == nomLat,
                              $sformatf("latency %0d, required %0d", lat, nomLat));
`endif
                    end
                    tally("result", quotient === e.q && remainder === e.r && div_by_zero === e.dbz,
                          $sformatf("got q=%0d r=%0d dbz=%b, required q=%0d r=%0d dbz=%b",
                                    quotient, remainder, div_by_zero, e.q, e.r, e.dbz));
                    if (out_ready) begin
                        void'(expQ.pop_front());
                        frontSeen = 0;
                    end
                end
            end
            prevStall = out_valid && !out_ready;
            if (in_valid && in_ready) begin
                a = longint'(dividend);
                b = longint'(divisor);
                e.acc = cycle;
                if (b == 0) begin
                    e.q   = '1;
                    e.r   = dividend[SW-1:0];
                    e.dbz = 1'b1;
                end else begin
                    e.q   = DW'(a / b);
                    e.r   = SW'(a % b);
                    e.dbz = 1'b0;
                end
                expQ.push_back(e);
                nAccepted++;
            end
        end
    end

    // Present one operand pair until it is accepted, then withdraw it.
    task automatic applyStimulus(input logic [DW-1:0] a, input logic [SW-1:0] b);
        int waited = 0;
        bit done = 0;
        @(posedge ap_clk); #1;
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        while (!done) begin
            @(negedge ap_clk);
            if (in_ready) begin
                done = 1;
                lastAcceptCycle = cycle;
            end else if (++waited > 100) begin
                tally("acceptTimeout", 1'b0, "in_ready=0 for 100 cycles, required 1");
                done = 1;
            end
        end
        @(posedge ap_clk); #1;
        in_valid = 1'b0;
        dividend = DW'($urandom);
        divisor  = SW'($urandom);
    endtask

    // Wait for a result, pin it against literal values, optionally hold it
    // under backpressure, then consume it and confirm the core is idle.
    task automatic checkOutput(input string name, input logic [DW-1:0] q, input logic [SW-1:0] r,
                               input logic dbz, input int lat, input int bpCycles);
        int waited = 0;
        bit seen = 0;
        bit expInReady;
`ifdef PFB_UDIV_SKID_EN
        expInReady = 1'b1;
`else
        expInReady = 1'b0;
`endif
        while (!seen && waited <= 100) begin
            @(negedge ap_clk);
            if (out_valid) seen = 1;
            else waited++;
        end
        tally({name, "_arrives"}, seen, "out_valid never rose, required 1");
        if (seen) begin
            tally({name, "_latency"}, (cycle - lastAcceptCycle) == lat,
                  $sformatf("latency %0d, required %0d", cycle - lastAcceptCycle, lat));
            tally({name, "_value"}, quotient === q && remainder === r && div_by_zero === dbz,
                  $sformatf("got q=%0d r=%0d dbz=%b, required q=%0d r=%0d dbz=%b",
                            quotient, remainder, div_by_zero, q, r, dbz));
            for (int i = 0; i < bpCycles; i++) begin
                @(negedge ap_clk);
                tally({name, "_hold"}, out_valid === 1'b1 && quotient === q && remainder === r &&
                      div_by_zero === dbz && in_ready === expInReady,
                      $sformatf("cycle %0d: valid=%b q=%0d r=%0d dbz=%b in_ready=%b, required 1/%0d/%0d/%b/%b",
                                i, out_valid, quotient, remainder, div_by_zero, in_ready, q, r, dbz, expInReady));
            end
            @(posedge ap_clk); #1;
            out_ready = 1'b1;
            @(posedge ap_clk); #1;
            out_ready = 1'b0;
            @(negedge ap_clk);
            tally({name, "_idle"}, out_valid === 1'b0 && in_ready === 1'b1,
                  $sformatf("after consume valid=%b in_ready=%b, required 0/1", out_valid, in_ready));
        end
    endtask

    function automatic logic [DW-1:0] pickDividend();
        case ($urandom_range(7))
            0:       return '1;
            1:       return DW'($urandom_range(15));
            default: return DW'($urandom);
        endcase
    endfunction

    function automatic logic [SW-1:0] pickDivisor();
        case ($urandom_range(15))
            0:       return '0;
            1:       return '1;
            2:       return SW'(1);
            3:       return SW'($urandom_range(15, 1));
            default: return SW'($urandom);
        endcase
    endfunction

    // Random traffic on both handshakes; the compare process does the checking.
    task automatic runRandom(input int nOps);
        int budget = 0;
        int startAcc = nAccepted;
        int drainWait = 0;
        while ((nAccepted - startAcc) < nOps && budget < 60000) begin
            @(posedge ap_clk); #1;
            in_valid  = ($urandom_range(3) != 0);
            dividend  = pickDividend();
            divisor   = pickDivisor();
            out_ready = $urandom_range(1) != 0;
            budget++;
        end
        tally("randomBudget", (nAccepted - startAcc) >= nOps,
              $sformatf("accepted %0d operations, required %0d", nAccepted - startAcc, nOps));
        @(posedge ap_clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (expQ.size() != 0 && drainWait < 100) begin
            @(negedge ap_clk);
            drainWait++;
        end
        tally("drain", expQ.size() == 0,
              $sformatf("%0d results still outstanding, required 0", expQ.size()));
        @(posedge ap_clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        bit sawValid = 0;
        ap_rst_n  = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(posedge ap_clk);
        @(negedge ap_clk);
        tally("resetState", in_ready === 1'b1 && out_valid === 1'b0 && quotient === '0 &&
              remainder === '0 && div_by_zero === 1'b0,
              $sformatf("in_ready=%b valid=%b q=%0d r=%0d dbz=%b, required 1/0/0/0/0",
                        in_ready, out_valid, quotient, remainder, div_by_zero));
        @(posedge ap_clk); #1;
        ap_rst_n = 1'b1;

        applyStimulus(23'd100000, 13'd37);
        checkOutput("div100000by37", 23'd2702, 13'd26, 1'b0, DW + 1, 0);
        applyStimulus(23'd8388607, 13'd8191);
        checkOutput("divMaxByMax", 23'd1024, 13'd1023, 1'b0, DW + 1, 0);
        applyStimulus(23'd5, 13'd1);
        checkOutput("div5by1", 23'd5, 13'd0, 1'b0, DW + 1, 0);
        applyStimulus(23'd12, 13'd4000);
        checkOutput("div12by4000", 23'd0, 13'd12, 1'b0, DW + 1, 0);
        applyStimulus(23'd1234, 13'd0);
        checkOutput("divByZero", 23'h7FFFFF, 13'd1234, 1'b1, 1, 0);
        applyStimulus(23'd4660, 13'd3);
        checkOutput("backpressure", 23'd1553, 13'd1, 1'b0, DW + 1, 10);

        // Reset in the middle of an operation discards it.
        applyStimulus(23'd100000, 13'd37);
        repeat (9) @(posedge ap_clk);
        #1 ap_rst_n = 1'b0;
        @(posedge ap_clk); #1;
        ap_rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge ap_clk);
            if (out_valid) sawValid = 1;
        end
        tally("resetDiscards", !sawValid && in_ready === 1'b1,
              $sformatf("saw out_valid=%b in_ready=%b after reset, required 0/1", sawValid, in_ready));
        applyStimulus(23'd77, 13'd7);
        checkOutput("div77by7", 23'd11, 13'd0, 1'b0, DW + 1, 0);

        runRandom(1200);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
